// File: rtl/mem_pkg.sv
// Shared memory-path definitions: default address/data widths, byte-enable
// width derivation and the drain FSM state encoding.
package mem_pkg;

  localparam int unsigned MEM_ADRW  = 30;
  localparam int unsigned MEM_DATAW = 32;

  function automatic int unsigned bew(input int unsigned dataw);
    return dataw / 8;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_e;

endpackage

// File: rtl/byte_merge.sv
// Byte-granular merge of a new partial word over an old one; the byte
// enables of the result are the union of both.
module byte_merge #(
  parameter  int unsigned DATAW = 32,
  localparam int unsigned BEW   = DATAW / 8
) (
  input  logic [DATAW-1:0] old_data_i,
  input  logic [BEW-1:0]   old_be_i,
  input  logic [DATAW-1:0] new_data_i,
  input  logic [BEW-1:0]   new_be_i,
  output logic [DATAW-1:0] data_o,
  output logic [BEW-1:0]   be_o
);

  always_comb begin
    data_o = old_data_i;
    for (int unsigned i = 0; i < BEW; i++) begin
      if (new_be_i[i]) data_o[8*i +: 8] = new_data_i[8*i +: 8];
    end
  end

  assign be_o = old_be_i | new_be_i;

endmodule

// File: rtl/coalescing_writebuffer.sv
// Coalescing write buffer: in-order FIFO of stores drained one word per
// memory transaction, merging stores into the youngest not-yet-issued entry.
module coalescing_writebuffer
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned ADRW  = MEM_ADRW,
  parameter  int unsigned DATAW = MEM_DATAW,
  localparam int unsigned BEW   = bew(DATAW),
  localparam int unsigned PTRW  = $clog2(DEPTH),
  localparam int unsigned CNTW  = PTRW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADRW-1:0]  adr,
  input  logic [DATAW-1:0] data,
  input  logic [BEW-1:0]   byteen,
  input  logic             en,
  output logic             done,
  output logic [ADRW-1:0]  memadr,
  output logic [DATAW-1:0] memdata,
  output logic [BEW-1:0]   membyteen,
  output logic             memen,
  input  logic             memdone,
  input  logic [ADRW-1:0]  snoopadr,
  output logic             snoophit,
  output logic [CNTW-1:0]  count
);

  logic [ADRW-1:0]  ent_adr_q  [DEPTH];
  logic [DATAW-1:0] ent_data_q [DEPTH];
  logic [BEW-1:0]   ent_be_q   [DEPTH];

  logic [PTRW-1:0]  head_q, head_d, tail_q, tail_d, young;
  logic [CNTW-1:0]  count_q, count_d;
  drain_state_e     state_q, state_d;
  logic [ADRW-1:0]  memadr_q;
  logic [DATAW-1:0] memdata_q;
  logic [BEW-1:0]   membyteen_q;

  logic             coalesce, merge, push, pop, issue, iss_hazard;
  logic [DATAW-1:0] merged_data;
  logic [BEW-1:0]   merged_be;
  logic [DEPTH-1:0] hit_vec;

  // Merging into a lone entry that is already in flight would change data under memory.
  assign young    = tail_q - PTRW'(1);
  assign coalesce = en && (count_q != '0) && (adr == ent_adr_q[young])
                    && !((state_q == BUSY) && (count_q == CNTW'(1)));
  assign done     = (count_q < CNTW'(DEPTH)) || coalesce;
  assign merge    = coalesce && (byteen != '0);
  assign push     = en && done && !coalesce && (byteen != '0);
  assign pop      = (state_q == BUSY) && memdone;

  byte_merge #(.DATAW(DATAW)) u_byte_merge (
    .old_data_i (ent_data_q[young]),
    .old_be_i   (ent_be_q[young]),
    .new_data_i (data),
    .new_be_i   (byteen),
    .data_o     (merged_data),
    .be_o       (merged_be)
  );

  // Drain FSM next-state plus pointer/occupancy bookkeeping.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNTW'(push) - CNTW'(pop);
    unique case (state_q)
      IDLE: if (count_q != '0) begin
        issue   = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (memdone) state_d = IDLE;
    endcase
    if (pop)  head_d = head_q + PTRW'(1);
    if (push) tail_d = tail_q + PTRW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A merge into the head on its own issue edge is forwarded so the bytes are not lost.
  assign iss_hazard = merge && (young == head_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      memadr_q    <= '0;
      memdata_q   <= '0;
      membyteen_q <= '0;
    end else if (issue) begin
      memadr_q    <= ent_adr_q[head_q];
      memdata_q   <= iss_hazard ? merged_data : ent_data_q[head_q];
      membyteen_q <= iss_hazard ? merged_be   : ent_be_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_adr_q[tail_q]  <= adr;
      ent_data_q[tail_q] <= data;
      ent_be_q[tail_q]   <= byteen;
    end
    if (merge) begin
      ent_data_q[young] <= merged_data;
      ent_be_q[young]   <= merged_be;
    end
  end

  // Snoop: an entry counts only while its offset from head is below occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
    logic [PTRW-1:0] off;
    assign off        = PTRW'(i) - head_q;
    assign hit_vec[i] = ({1'b0, off} < count_q) && (ent_adr_q[i] == snoopadr);
  end

  assign snoophit  = |hit_vec;
  assign memen     = (state_q == BUSY);
  assign memadr    = memadr_q;
  assign memdata   = memdata_q;
  assign membyteen = membyteen_q;
  assign count     = count_q;

endmodule

// File: tb/tb_coalescing_writebuffer.sv
// Scoreboard bench for coalescing_writebuffer: a reference queue tracks
// queued stores and is checked against every drained transaction.
module tb_coalescing_writebuffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ADRW  = 30;
  localparam int unsigned DATAW = 32;
  localparam int unsigned BEW   = 4;

  typedef struct packed {
    logic [ADRW-1:0]  adr;
    logic [DATAW-1:0] data;
    logic [BEW-1:0]   be;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [ADRW-1:0]  adr;
  logic [DATAW-1:0] data;
  logic [BEW-1:0]   byteen;
  logic             en;
  logic             done;
  logic [ADRW-1:0]  memadr;
  logic [DATAW-1:0] memdata;
  logic [BEW-1:0]   membyteen;
  logic             memen;
  logic             memdone;
  logic [ADRW-1:0]  snoopadr;
  logic             snoophit;
  logic [2:0]       count;

  ent_t sb[$];
  ent_t drained_q[$];
  logic m_memen;
  ent_t m_out;
  logic last_acc;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  coalescing_writebuffer #(.DEPTH(DEPTH), .ADRW(ADRW), .DATAW(DATAW)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .data      (data),
    .byteen    (byteen),
    .en        (en),
    .done      (done),
    .memadr    (memadr),
    .memdata   (memdata),
    .membyteen (membyteen),
    .memen     (memen),
    .memdone   (memdone),
    .snoopadr  (snoopadr),
    .snoophit  (snoophit),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t bmerge(input ent_t o, input logic [DATAW-1:0] d, input logic [BEW-1:0] b);
    logic [DATAW-1:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    bmerge      = o;
    bmerge.data = (o.data & ~m) | (d & m);
    bmerge.be   = o.be | b;
  endfunction

  function automatic logic model_snoop(input logic [ADRW-1:0] a);
    model_snoop = 1'b0;
    foreach (sb[k]) if (sb[k].adr == a) model_snoop = 1'b1;
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic coal, acc, iss, pop;
    int   n;
    #1;
    n    = sb.size();
    coal = en && (n > 0) && (adr == sb[n-1].adr) && !(m_memen && n == 1);
    acc  = en && ((n < DEPTH) || coal);
    iss  = !m_memen && (n > 0);
    pop  = m_memen && memdone;
    if (!reset) begin
      chk("done", done, (n < DEPTH) || coal);
      chk("snoophit", snoophit, model_snoop(snoopadr));
      if (pop) begin
        chk("drain_adr", memadr, sb[0].adr);
        chk("drain_data", memdata, sb[0].data);
        chk("drain_be", membyteen, sb[0].be);
      end
    end
    @(posedge clk);
    last_acc = acc && !reset;
    if (reset) begin
      sb.delete();
      m_memen = 1'b0;
      m_out   = '0;
    end else begin
      if (acc && byteen != '0 && coal) sb[n-1] = bmerge(sb[n-1], data, byteen);
      if (iss) begin
        m_out   = sb[0];
        m_memen = 1'b1;
      end
      if (pop) begin
        drained_q.push_back(sb.pop_front());
        m_memen = 1'b0;
      end
      if (acc && byteen != '0 && !coal) sb.push_back({adr, data, byteen});
    end
    #1;
    chk("count", count, sb.size());
    chk("memen", memen, m_memen);
    if (m_memen) begin
      chk("memadr", memadr, m_out.adr);
      chk("memdata", memdata, m_out.data);
      chk("membyteen", membyteen, m_out.be);
    end
  endtask

  task automatic store(input logic [ADRW-1:0] a, input logic [DATAW-1:0] d, input logic [BEW-1:0] b);
    en = 1'b1; adr = a; data = d; byteen = b;
    last_acc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (last_acc) break;
    end
    en = 1'b0;
    if (!last_acc) chk("store_timeout", 0, 1);
  endtask

  task automatic drain();
    en = 1'b0; memdone = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !m_memen) break;
      step();
    end
    chk("drain_empty", count, 0);
    memdone = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; adr = '0; data = '0; byteen = '0;
    memdone = 1'b0; snoopadr = '0; m_memen = 1'b0; m_out = '0; last_acc = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_memen", memen, 0);
    chk("rst_memadr", memadr, 0);
    chk("rst_memdata", memdata, 0);
    chk("rst_membyteen", membyteen, 0);

    // Single store into empty buffer, zero-wait memory.
    memdone = 1'b1;
    store(30'h0, 32'hDEADBEEF, 4'hF);
    chk("single_not_issued", memen, 0);
    step();
    chk("single_memen", memen, 1);
    chk("single_adr", memadr, 0);
    chk("single_data", memdata, 32'hDEADBEEF);
    chk("single_be", membyteen, 4'hF);
    step();
    chk("single_count", count, 0);
    chk("single_idle", memen, 0);

    // Coalesce behind a different word in flight.
    memdone = 1'b0; drained_q.delete();
    store(30'h1, 32'h0, 4'hF);
    store(30'h10, 32'hAABBCCDD, 4'h3);
    store(30'h10, 32'h11223344, 4'hC);
    chk("coal_count", count, 2);
    drain();
    chk("coal_ndrain", drained_q.size(), 2);
    if (drained_q.size() == 2) begin
      chk("coal_data", drained_q[1].data, 32'h1122CCDD);
      chk("coal_be", drained_q[1].be, 4'hF);
    end

    // Same word as the in-flight lone entry must not merge.
    drained_q.delete();
    store(30'h5, 32'h55, 4'hF);
    step();
    chk("nomerge_busy", memen, 1);
    store(30'h5, 32'h55, 4'hF);
    chk("nomerge_count", count, 2);
    drain();
    chk("nomerge_ndrain", drained_q.size(), 2);

    // Full buffer back-pressure.
    drained_q.delete();
    for (int k = 0; k < 4; k++) store(30'h100 + 30'(k), 32'hC0DE0000 + 32'(k), 4'hF);
    en = 1'b1; adr = 30'h104; data = 32'hC0DE0004; byteen = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1 chk("full_done", done, 0);
      step();
    end
    memdone = 1'b1;
    store(30'h104, 32'hC0DE0004, 4'hF);
    drain();
    chk("full_ndrain", drained_q.size(), 5);
    foreach (drained_q[k]) chk("full_order", drained_q[k].adr, 64'h100 + 64'(k));

    // Snoop queued, in flight, miss, and after drain.
    store(30'h20, 32'h1234, 4'hF);
    snoopadr = 30'h20;
    #1 chk("snoop_queued", snoophit, 1);
    step();
    chk("snoop_inflight", snoophit, 1);
    snoopadr = 30'h21;
    #1 chk("snoop_miss", snoophit, 0);
    drain();
    snoopadr = 30'h20;
    #1 chk("snoop_drained", snoophit, 0);

    // Reset in the middle of a transaction.
    drained_q.delete();
    store(30'h30, 32'h30, 4'hF);
    store(30'h31, 32'h31, 4'hF);
    store(30'h32, 32'h32, 4'hF);
    chk("mid_count", count, 3);
    chk("mid_memen", memen, 1);
    reset = 1'b1; memdone = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_memen", memen, 0);
    step(); step();
    chk("mid_after_count", count, 0);
    chk("mid_after_drain", drained_q.size(), 0);
    memdone = 1'b0;

    // Randomised traffic over a small address set for merges and stalls.
    for (int k = 0; k < 200; k++) begin
      en       = 1'($urandom_range(0, 1));
      adr      = 30'($urandom_range(32'h40, 32'h42));
      data     = $urandom;
      byteen   = 4'($urandom_range(0, 15));
      memdone  = 1'($urandom_range(0, 1));
      snoopadr = 30'($urandom_range(32'h40, 32'h43));
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/coalescing_writebuffer.md
# coalescing_writebuffer

Parametrised, coalescing write buffer between the data cache's write-through path and the memory arbiter. Stores are queued in a circular FIFO of DEPTH entries and drained to memory one word per transaction, in order. A store to the same word as the youngest queued, not-yet-issued entry is byte-merged into it. An address snoop port lets the data cache detect loads that hit pending stores.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- ADRW, 30: word-address width.
- DATAW, 32: data width; multiple of 8; BEW = DATAW/8 byte enables.
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- adr  in  ADRW  store word address.
- data  in  DATAW  store data.
- byteen  in  BEW  store byte enables; bit i covers data[8i+7:8i].
- en  in  1  store request.
- done  out  1  combinational accept; a store transfers on a posedge with en & done.
- memadr  out  ADRW  registered drain address.
- memdata  out  DATAW  registered drain data.
- membyteen  out  BEW  registered drain byte enables.
- memen  out  1  registered drain request.
- memdone  in  1  memory acknowledge; sampled only while memen=1.
- snoopadr  in  ADRW  load address from the data cache.
- snoophit  out  1  combinational; 1 if any valid entry, including the in-flight one, has adr == snoopadr.
- count  out  $clog2(DEPTH)+1  registered occupancy.

## Operation
- State: head/tail pointers ($clog2(DEPTH) bits, natural wrap), count, per-entry adr/data/byteen, and inflight = memen.
- The youngest entry is at tail-1, valid when count>0.
- Coalesce condition: en & count>0 & adr == entry[tail-1].adr & ~(memen & count==1).
  - The last term prevents merging into the in-flight head.
- done = (count < DEPTH) | coalesce.
- Accept with coalesce: for each byte i with byteen[i]=1, entry[tail-1] byte i ← data byte i; entry byteen ← old OR new. Tail and count are unchanged.
- Accept without coalesce: write entry[tail], tail+1, count+1.
- Accept with byteen == 0: done follows the rules above, but nothing is stored.
- Drain FSM, two states:
  - IDLE (memen=0): if count>0 at the edge, latch entry[head] into memadr/memdata/membyteen, memen ← 1, go to BUSY.
  - BUSY (memen=1): memadr/memdata/membyteen stay stable. On an edge with memdone=1: head+1, count−1, memen ← 0, go to IDLE.
- There is always at least one memen=0 cycle between transactions.
- Simultaneous non-coalescing push and pop: count is unchanged; both pointers advance.
- A push when full is only possible by coalescing. When full and not coalescing, done=0 and the store is held off.
- The count used for the IDLE issue decision is the value before the same edge's push. A store into an empty buffer is therefore not issued on its own accept edge.
- memdone while memen=0 is ignored.

## Timing
- Reset (synchronous): head=tail=0, count=0, memen=0, memadr=0, memdata=0, membyteen=0. Entry storage is not cleared.
- Reset mid-transaction: all entries are discarded, and memen=0 after the reset edge regardless of memdone.
- Latency, store into empty buffer accepted at edge k: memen=1 after edge k+1. With memdone=1 at edge k+2, count=0 after k+2.
- Throughput: one word per 2 cycles minimum with a zero-wait memory (memdone=1 on the first BUSY edge).
- done and snoophit are combinational from registered state and current inputs. There is no combinational path from memdone to any output.
- snoophit ignores en. It does not reflect a store accepted on the same edge until the following cycle.

## Structure
- Shared package mem_pkg: ADRW and DATAW defaults, BEW derivation, and the drain FSM state enum (IDLE, BUSY). The cache and arbiter reuse these.
- Sub-module byte_merge (combinational, parameter DATAW): inputs old data/byteen and new data/byteen; outputs merged data/byteen. It is used for coalescing and is reusable by the cache's partial-write path.
- The snoop comparator is a generate loop over DEPTH entries, OR-reduced, with each entry qualified by its occupancy (index within [head, head+count)).

## Test plan
- Single store: adr=0x0, data=0xDEADBEEF, byteen=1111, memdone=1 while BUSY. Expect memen high one cycle after accept, memadr=0 / memdata=DEADBEEF / membyteen=1111, then count=0.
- Coalesce: with memdone held 0 and a different word in flight at head, store adr=0x10 data=0xAABBCCDD be=0011, then adr=0x10 data=0x11223344 be=1100. Expect count=2 and, when drained, data=0x1122CCDD, be=1111.
- No merge into in-flight: while entry adr=0x5 is BUSY, store adr=0x5 be=1111 data=0x55. Expect count 1→2 and two separate drain transactions, in order.
- Full/back-pressure: DEPTH=4, memdone=0, five distinct-address stores. Expect done=0 on the 5th until the first memdone, and no entry lost or reordered.
- Snoop: queue adr=0x20. Expect snoophit=1 for snoopadr=0x20 (both queued and in flight) and 0 for 0x21; snoophit=0 after drain.
- Reset mid-transaction: with memen=1 and count=3, assert reset for one edge. Expect count=0 and memen=0; a following memdone pulse has no effect.
